// File: rtl/sign_ext.sv
// sign_ext: widens a WIDTH-bit immediate to 32 bits and holds a decode->execute pipeline copy
module sign_ext #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a,
    input  logic [1:0]       extop,
    input  logic             in_valid,
    input  logic             en,
    input  logic             flush,
    output logic [31:0]      y,
    output logic [31:0]      y_q,
    output logic             valid_q
);
    logic [31:0] zx, sx, lu;

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad
            $error("sign_ext: WIDTH must be in 1..32");
        end else if (WIDTH == 32) begin : g_full
            assign zx = a;
            assign sx = a;
            assign lu = a;
        end else begin : g_part
            assign zx = {{(32-WIDTH){1'b0}}, a};
            assign sx = {{(32-WIDTH){a[WIDTH-1]}}, a};
            assign lu = {a, {(32-WIDTH){1'b0}}};
        end
    endgenerate

    // select extension mode; branch offset drops the two MSBs of the sign-extended value
    always_comb begin
        y = extop == 2'b00 ? zx :
            extop == 2'b01 ? sx :
            extop == 2'b10 ? lu : {sx[29:0], 2'b00};
    end

    // pipeline slot: reset beats flush, flush beats advance, otherwise stall holds
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            y_q     <= '0;
            valid_q <= 1'b0;
        end else if (flush) begin
            y_q     <= '0;
            valid_q <= 1'b0;
        end else if (en) begin
            y_q     <= y;
            valid_q <= in_valid;
        end
    end
endmodule

// File: tb/tb_sign_ext.sv
// tb_sign_ext: scoreboard bench for sign_ext at WIDTH 8, 16 and 32
module tb_sign_ext;
    typedef struct packed {
        logic [2:0][31:0] y;
        logic [2:0][31:0] q;
        logic [2:0]       v;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n, in_valid, en, flush;
    logic [1:0]  extop;
    logic [7:0]  a8;
    logic [15:0] a16;
    logic [31:0] a32;
    logic [31:0] y8, y16, y32, q8, q16, q32;
    logic        v8, v16, v32;

    exp_t        sb[$];
    logic [2:0][31:0] m_q;
    logic [2:0]  m_v;
    int          checks = 0;
    int          errors = 0;
    bit          done = 0;

    always #5 clk = ~clk;

    sign_ext #(.WIDTH(8)) u8 (.clk(clk), .reset_n(reset_n), .a(a8), .extop(extop), .in_valid(in_valid),
        .en(en), .flush(flush), .y(y8), .y_q(q8), .valid_q(v8));
    sign_ext #(.WIDTH(16)) u16 (.clk(clk), .reset_n(reset_n), .a(a16), .extop(extop), .in_valid(in_valid),
        .en(en), .flush(flush), .y(y16), .y_q(q16), .valid_q(v16));
    sign_ext #(.WIDTH(32)) u32 (.clk(clk), .reset_n(reset_n), .a(a32), .extop(extop), .in_valid(in_valid),
        .en(en), .flush(flush), .y(y32), .y_q(q32), .valid_q(v32));

    // reference: treat the immediate as an integer and apply each mode arithmetically
    function automatic logic [31:0] ref_y(input logic [31:0] av, input int w, input logic [1:0] op);
        longint u, s, r;
        u = longint'(av) & ((64'sd1 <<< w) - 1);
        s = (u >= (64'sd1 <<< (w - 1))) ? u - (64'sd1 <<< w) : u;
        case (op)
            2'd0: r = u;
            2'd1: r = s;
            2'd2: r = u * (64'sd1 <<< (32 - w));
            default: r = s * 4;
        endcase
        return r[31:0];
    endfunction

    task automatic step(input logic rn, input logic e, input logic f, input logic iv,
                        input logic [1:0] op, input logic [31:0] av);
        exp_t x;
        int   w[3];
        w = '{8, 16, 32};
        @(negedge clk);
        reset_n = rn; en = e; flush = f; in_valid = iv; extop = op;
        a32 = av; a16 = av[15:0]; a8 = av[7:0];
        for (int i = 0; i < 3; i++) begin
            x.y[i] = ref_y(av, w[i], op);
            if (!rn || f) begin
                m_q[i] = '0;
                m_v[i] = 1'b0;
            end else if (e) begin
                m_q[i] = x.y[i];
                m_v[i] = iv;
            end
        end
        x.q = m_q;
        x.v = m_v;
        sb.push_back(x);
    endtask

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, got, want, $time);
        end
    endtask

    // monitor: one edge after each stimulus, compare comb and registered outputs
    initial begin
        exp_t x;
        while (!done || sb.size() != 0) begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                chk("y_w8", y8, x.y[0]);
                chk("y_w16", y16, x.y[1]);
                chk("y_w32", y32, x.y[2]);
                chk("yq_w8", q8, x.q[0]);
                chk("yq_w16", q16, x.q[1]);
                chk("yq_w32", q32, x.q[2]);
                chk("vq_w8", {31'b0, v8}, {31'b0, x.v[0]});
                chk("vq_w16", {31'b0, v16}, {31'b0, x.v[1]});
                chk("vq_w32", {31'b0, v32}, {31'b0, x.v[2]});
            end
        end
    end

    initial begin
        logic [31:0] r;
        m_q = '0;
        m_v = '0;
        reset_n = 0; en = 1; flush = 0; in_valid = 1; extop = 0; a8 = 0; a16 = 0; a32 = 0;
        step(0, 1, 0, 1, 2'b00, 32'h1234);
        step(0, 1, 0, 1, 2'b00, 32'h1234);
        step(1, 1, 0, 1, 2'b00, 32'h1234);
        for (int m = 0; m < 4; m++) step(1, 1, 0, 1, 2'(m), 32'h0000FFF0);
        for (int m = 0; m < 4; m++) step(1, 1, 0, 1, 2'(m), 32'h000000FF);
        step(1, 1, 0, 1, 2'b01, 32'h00008000);
        step(1, 1, 0, 1, 2'b01, 32'h0000FFF0);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 2'b01, 32'h00000001);
        step(0, 0, 0, 1, 2'b01, 32'h00000001);
        step(1, 1, 0, 1, 2'b01, 32'h0000FFF0);
        step(1, 1, 1, 1, 2'b01, 32'h00001111);
        step(1, 1, 0, 1, 2'b00, 32'h00002222);
        step(1, 1, 0, 0, 2'b11, 32'h00003333);
        for (int m = 0; m < 4; m++) step(1, 1, 0, 1, 2'(m), 32'h80000080);
        for (int m = 0; m < 4; m++) step(1, 1, 0, 1, 2'(m), 32'h80000001);
        for (int k = 0; k < 400; k++) begin
            r = $urandom;
            step(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                 1'($urandom), 2'($urandom), r);
        end
        done = 1;
        repeat (5) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
